// File: rtl/bkm_pkg.sv
// Shared types and constants for the Barker symbol-timing synchroniser.
// Holds the sync state encoding plus default period and chip counter width.
package bkm_pkg;

    localparam int BKM_PERIOD = 11;
    localparam int BKM_CNT_W  = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } sync_state_t;

endpackage

// File: rtl/bkm_chip_counter.sv
// Modulo-PERIOD chip counter with load-zero; slot flags are combinational from the register.
// Advances only on en_i; clr_i zeroes it regardless of en_i.
module bkm_chip_counter
    import bkm_pkg::*;
#(
    parameter int PERIOD = BKM_PERIOD,
    parameter int CNT_W  = BKM_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic load_zero_i,
    output logic slot_exp_o,
    output logic slot_early_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(PERIOD - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (load_zero_i || (cnt_q == CNT_LAST)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_exp_o   = (cnt_q == CNT_LAST);
    assign slot_early_o = (cnt_q == CNT_EARLY);

endmodule

// File: rtl/barker_frame_sync.sv
// Barker symbol-timing synchroniser: SEARCH/VERIFY/LOCK with flywheel; outputs registered, 1 cycle after the deciding chip.
// No backpressure; chip_en low freezes everything. BKM_SYNC_TOL_EN enables +/-1 chip tolerance in LOCK.
module barker_frame_sync
    import bkm_pkg::*;
#(
    parameter int PERIOD    = BKM_PERIOD,
    parameter int CONFIRM_N = 3,
    parameter int MISS_MAX  = 4,
    parameter int CNT_W     = BKM_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_en,
    input  logic       peak_in,
    input  logic       restart,
    output logic       lock,
    output logic       sym_strobe,
    output logic       sym_bit,
    output logic [1:0] sync_state
);

    localparam int HC_W = $clog2(CONFIRM_N + 1);
    localparam int MC_W = $clog2(MISS_MAX + 1);
    localparam logic [HC_W-1:0] HIT_LAST  = HC_W'(CONFIRM_N - 1);
    localparam logic [MC_W-1:0] MISS_LAST = MC_W'(MISS_MAX - 1);

    sync_state_t     state_q;
    logic [HC_W-1:0] hit_cnt_q;
    logic [MC_W-1:0] miss_cnt_q;
    logic            lock_q;
    logic            strobe_q;
    logic            bit_q;

    logic slot_exp;
    logic slot_early;
    logic exp_hit;
    logic exp_miss;
    logic lock_hit;
    logic lock_miss;
    logic load_zero;

`ifdef BKM_SYNC_TOL_EN
    logic pend_q;
`else
    logic unused_slot_early;
    assign unused_slot_early = slot_early;
`endif

    bkm_chip_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_chip_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (restart),
        .en_i         (chip_en),
        .load_zero_i  (load_zero),
        .slot_exp_o   (slot_exp),
        .slot_early_o (slot_early)
    );

    always_comb begin
        exp_hit  = chip_en & slot_exp & peak_in;
        exp_miss = chip_en & slot_exp & ~peak_in;
`ifdef BKM_SYNC_TOL_EN
        // A pending slot resolves on the very next chip; an early peak realigns immediately.
        lock_hit  = exp_hit | (chip_en & peak_in & (slot_early | pend_q));
        lock_miss = chip_en & pend_q & ~peak_in;
`else
        lock_hit  = exp_hit;
        lock_miss = exp_miss;
`endif
        load_zero = 1'b0;
        case (state_q)
            SEARCH:  load_zero = chip_en & peak_in;
            VERIFY:  load_zero = exp_hit;
            LOCK:    load_zero = lock_hit;
            default: load_zero = 1'b0;
        endcase
    end

`ifdef BKM_SYNC_TOL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (restart) begin
            pend_q <= 1'b0;
        end else if (chip_en) begin
            pend_q <= (state_q == LOCK) & exp_miss;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            lock_q     <= 1'b0;
            strobe_q   <= 1'b0;
            bit_q      <= 1'b0;
        end else if (restart) begin
            state_q    <= SEARCH;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            lock_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (chip_en) begin
                case (state_q)
                    SEARCH: begin
                        if (peak_in) begin
                            state_q   <= VERIFY;
                            hit_cnt_q <= HC_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (exp_hit) begin
                            hit_cnt_q <= hit_cnt_q + HC_W'(1);
                            if (hit_cnt_q == HIT_LAST) begin
                                state_q    <= LOCK;
                                lock_q     <= 1'b1;
                                miss_cnt_q <= '0;
                            end
                        end else if (exp_miss) begin
                            state_q   <= SEARCH;
                            hit_cnt_q <= '0;
                        end
                    end
                    LOCK: begin
                        if (lock_hit) begin
                            strobe_q   <= 1'b1;
                            bit_q      <= 1'b1;
                            miss_cnt_q <= '0;
                        end else if (lock_miss) begin
                            // The slot that exhausts the flywheel is not strobed.
                            if (miss_cnt_q == MISS_LAST) begin
                                state_q    <= SEARCH;
                                lock_q     <= 1'b0;
                                hit_cnt_q  <= '0;
                                miss_cnt_q <= '0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + MC_W'(1);
                                strobe_q   <= 1'b1;
                                bit_q      <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lock       = lock_q;
    assign sym_strobe = strobe_q;
    assign sym_bit    = bit_q;
    assign sync_state = state_q;

endmodule
